// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - command/response stream and APB bus bundle for apb_master_bridge
//
// Purpose: groups the command stream, response stream and APB master bus
//   of apb_master_bridge into one interface. Clock and reset stay outside.
// Modports:
//   master - the bridge side. It consumes commands, produces responses and
//            drives the APB bus.
//   slave  - the environment side. It produces commands, consumes responses
//            and answers on the APB bus.
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_strb/req_prot
//     - command stream.
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err
//     - response stream.
//   pselx/penable/pwrite/paddr/pwdata/pstrb/pprot
//     - APB request (bridge outputs).
//   pready/pslverr/prdata
//     - per-slave APB completion lanes (bridge inputs).
interface apb_master_bridge_if #(
  parameter int dataWidth  = 32,
  parameter int addrWidth  = 32,
  parameter int NUM_SLAVES = 4
);
  localparam int strbWidth = dataWidth / 8;

  logic                             req_valid;
  logic                             req_ready;
  logic                             req_write;
  logic [addrWidth-1:0]             req_addr;
  logic [dataWidth-1:0]             req_wdata;
  logic [strbWidth-1:0]             req_strb;
  logic [2:0]                       req_prot;

  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [dataWidth-1:0]             rsp_rdata;
  logic                             rsp_err;

  logic [NUM_SLAVES-1:0]            pselx;
  logic                             penable;
  logic                             pwrite;
  logic [addrWidth-1:0]             paddr;
  logic [dataWidth-1:0]             pwdata;
  logic [strbWidth-1:0]             pstrb;
  logic [2:0]                       pprot;
  logic [NUM_SLAVES-1:0]            pready;
  logic [NUM_SLAVES-1:0]            pslverr;
  logic [NUM_SLAVES*dataWidth-1:0]  prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - registered APB master driven by a valid/ready command stream
//
// Purpose: accepts one command at a time and runs a full APB SETUP/ACCESS
//   transfer to the slave selected by req_addr[SEL_LSB +: SELW]. It returns
//   read data and error status on the response stream. Every bus and
//   response output is a flop, so nothing from pready/prdata reaches an
//   output combinationally.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
//   TIMEOUT_CYCLES cycles without pready. The abort reports rsp_err=1.
//   Without the macro, ACCESS waits indefinitely.
// Ports:
//   pclk - clock; all logic runs on the rising edge.
//   prst - synchronous active-high reset. It aborts any transfer in flight.
//   bus  - apb_master_bridge_if.master: command stream, response stream and
//          APB bus.
module apb_master_bridge #(
  parameter int dataWidth      = 32,
  parameter int addrWidth      = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                 pclk,
  input logic                 prst,
  apb_master_bridge_if.master bus
);
  localparam int SELW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int SELW1     = SELW + 1;
  localparam int strbWidth = dataWidth / 8;
  localparam logic [SELW:0] numSlavesW = SELW1'(NUM_SLAVES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} stateT;

  stateT                 state;
  logic [SELW-1:0]       curIdx;
  logic [SELW-1:0]       reqIdx;
  logic                  decodeOk;
  logic [NUM_SLAVES-1:0] reqSel;
  logic                  selReady;
  logic                  selErr;
  logic [dataWidth-1:0]  selData;

`ifdef APB_TIMEOUT_EN
  localparam int toWidth = $clog2(TIMEOUT_CYCLES);
  localparam logic [toWidth-1:0] toLast = toWidth'(TIMEOUT_CYCLES - 1);
  logic [toWidth-1:0] toCnt;
`endif

  assign reqIdx   = bus.req_addr[SEL_LSB +: SELW];
  // Index field values at or above NUM_SLAVES have no slave behind them.
  assign decodeOk = ({1'b0, reqIdx} < numSlavesW);

  // Decode and lane muxing use explicit loops rather than direct bit
  // indexing. This keeps index widths legal for every NUM_SLAVES, including 1.
  always_comb begin
    reqSel   = '0;
    selReady = 1'b0;
    selErr   = 1'b0;
    selData  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      reqSel[i] = (reqIdx == i[SELW-1:0]);
      if (curIdx == i[SELW-1:0]) begin
        selReady = bus.pready[i];
        selErr   = bus.pslverr[i];
        selData  = bus.prdata[i*dataWidth +: dataWidth];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state         <= IDLE;
      curIdx        <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.pselx     <= '0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.pstrb     <= '0;
      bus.pprot     <= '0;
`ifdef APB_TIMEOUT_EN
      toCnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // req_ready is registered high in IDLE, so req_valid alone is the handshake.
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            if (decodeOk) begin
              curIdx      <= reqIdx;
              bus.pselx   <= reqSel;
              bus.penable <= 1'b0;
              bus.pwrite  <= bus.req_write;
              bus.paddr   <= bus.req_addr;
              bus.pwdata  <= bus.req_wdata;
              bus.pstrb   <= bus.req_write ? bus.req_strb : {strbWidth{1'b0}};
              bus.pprot   <= bus.req_prot;
              state       <= SETUP;
            end else begin
              // Unmapped slave: answer directly and leave the APB bus untouched.
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
              state         <= RESP;
            end
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          toCnt       <= '0;
`endif
          state       <= ACCESS;
        end
        ACCESS: begin
          if (selReady) begin
            bus.rsp_rdata <= bus.pwrite ? {dataWidth{1'b0}} : selData;
            bus.rsp_err   <= selErr;
            bus.rsp_valid <= 1'b1;
            bus.pselx     <= '0;
            bus.penable   <= 1'b0;
            state         <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (toCnt == toLast) begin
            // The slave never answered: abort the transfer and report an error.
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.pselx     <= '0;
            bus.penable   <= 1'b0;
            state         <= RESP;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge
module tb_apb_master_bridge;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NS  = 4;
  localparam int NS3 = 3;

  logic pclk = 1'b0;
  logic prst;
  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.dataWidth(DW), .addrWidth(AW), .NUM_SLAVES(NS))  bus();
  apb_master_bridge_if #(.dataWidth(DW), .addrWidth(AW), .NUM_SLAVES(NS3)) bus3();

  apb_master_bridge #(.dataWidth(DW), .addrWidth(AW), .NUM_SLAVES(NS),
                      .SEL_LSB(12), .TIMEOUT_CYCLES(8))
    dut (.pclk(pclk), .prst(prst), .bus(bus));

  apb_master_bridge #(.dataWidth(DW), .addrWidth(AW), .NUM_SLAVES(NS3),
                      .SEL_LSB(12), .TIMEOUT_CYCLES(8))
    dut3 (.pclk(pclk), .prst(prst), .bus(bus3));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    int          holdRsp;
    logic [31:0] slvData;
    logic        slvErr;
    logic [3:0]  expSel;
    logic [3:0]  expStrb;
    logic [31:0] expRdata;
    logic        expErr;
  } vecT;

  vecT vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic runTxn(input vecT v, input string tag);
    int lane;
    lane = 0;
    for (int i = 0; i < NS; i++) if (v.expSel[i]) lane = i;
    // Unselected slaves answer ready+error with junk data; the bridge must ignore them.
    for (int i = 0; i < NS; i++) begin
      bus.prdata[i*DW +: DW] = 32'hBAD0_0000 | i;
      bus.pready[i]          = 1'b1;
      bus.pslverr[i]         = 1'b1;
    end
    bus.prdata[lane*DW +: DW] = v.slvData;
    bus.pready[lane]          = 1'b0;
    bus.pslverr[lane]         = v.slvErr;
    chk({tag, "/idle_req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_strb  = v.strb;
    bus.req_prot  = v.prot;
    bus.rsp_ready = 1'b0;
    tick;
    // Scramble the command inputs so that only captured values can pass.
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h5A5A_5A5A;
    bus.req_wdata = 32'hFFFF_0000;
    bus.req_strb  = 4'h0;
    bus.req_prot  = 3'h0;
    bus.req_write = ~v.write;
    chk({tag, "/setup_pselx"},   64'(bus.pselx),     64'(v.expSel));
    chk({tag, "/setup_penable"}, 64'(bus.penable),   64'd0);
    chk({tag, "/setup_paddr"},   64'(bus.paddr),     64'(v.addr));
    chk({tag, "/setup_pwrite"},  64'(bus.pwrite),    64'(v.write));
    chk({tag, "/setup_pwdata"},  64'(bus.pwdata),    64'(v.wdata));
    chk({tag, "/setup_pstrb"},   64'(bus.pstrb),     64'(v.expStrb));
    chk({tag, "/setup_pprot"},   64'(bus.pprot),     64'(v.prot));
    chk({tag, "/setup_ready"},   64'(bus.req_ready), 64'd0);
    chk({tag, "/setup_rvalid"},  64'(bus.rsp_valid), 64'd0);
    tick;
    for (int w = 0; w <= v.waits; w++) begin
      chk({tag, "/acc_pselx"},   64'(bus.pselx),     64'(v.expSel));
      chk({tag, "/acc_penable"}, 64'(bus.penable),   64'd1);
      chk({tag, "/acc_paddr"},   64'(bus.paddr),     64'(v.addr));
      chk({tag, "/acc_pwdata"},  64'(bus.pwdata),    64'(v.wdata));
      chk({tag, "/acc_pstrb"},   64'(bus.pstrb),     64'(v.expStrb));
      chk({tag, "/acc_rvalid"},  64'(bus.rsp_valid), 64'd0);
      bus.pready[lane] = (w == v.waits);
      tick;
    end
    bus.pready[lane] = 1'b0;
    chk({tag, "/rsp_valid"},   64'(bus.rsp_valid), 64'd1);
    chk({tag, "/rsp_rdata"},   64'(bus.rsp_rdata), 64'(v.expRdata));
    chk({tag, "/rsp_err"},     64'(bus.rsp_err),   64'(v.expErr));
    chk({tag, "/rsp_pselx"},   64'(bus.pselx),     64'd0);
    chk({tag, "/rsp_penable"}, 64'(bus.penable),   64'd0);
    chk({tag, "/rsp_paddr"},   64'(bus.paddr),     64'(v.addr));
    for (int h = 0; h < v.holdRsp; h++) begin
      tick;
      chk({tag, "/hold_valid"}, 64'(bus.rsp_valid), 64'd1);
      chk({tag, "/hold_rdata"}, 64'(bus.rsp_rdata), 64'(v.expRdata));
      chk({tag, "/hold_err"},   64'(bus.rsp_err),   64'(v.expErr));
      chk({tag, "/hold_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    chk({tag, "/done_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "/done_ready"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accCycles;
    int seen;
    bit got;

    //          wr    addr          wdata         strb  prot   wt hold slvData       err sel      strb  rdata         err
    vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 0, 32'h1111_1111, 1'b0, 4'b0010, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_3000, 32'h5555_AAAA, 4'hF, 3'b010, 3, 0, 32'h1234_5678, 1'b0, 4'b1000, 4'h0, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_2010, 32'h0BAD_F00D, 4'h5, 3'b001, 0, 5, 32'h7777_7777, 1'b1, 4'b0100, 4'h5, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'h3, 3'b111, 1, 2, 32'hA5A5_0001, 1'b0, 4'b0001, 4'h0, 32'hA5A5_0001, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_2FFC, 32'h0000_0000, 4'h0, 3'b000, 2, 0, 32'hCAFE_F00D, 1'b1, 4'b0100, 4'h0, 32'hCAFE_F00D, 1'b1};
    vecs[5] = '{1'b1, 32'hFFFF_1FFC, 32'h0123_4567, 4'h8, 3'b100, 0, 1, 32'h89AB_CDEF, 1'b0, 4'b0010, 4'h8, 32'h0000_0000, 1'b0};

    prst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_strb = '0; bus.req_prot = '0; bus.rsp_ready = 1'b0;
    bus.pready = '0; bus.pslverr = '0; bus.prdata = '0;
    bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
    bus3.req_strb = '0; bus3.req_prot = '0; bus3.rsp_ready = 1'b0;
    bus3.pready = '1; bus3.pslverr = '0;
    bus3.prdata = {32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
    tick;
    tick;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
    chk("rst_pselx",     64'(bus.pselx),     64'd0);
    chk("rst_penable",   64'(bus.penable),   64'd0);
    chk("rst_pwrite",    64'(bus.pwrite),    64'd0);
    chk("rst_paddr",     64'(bus.paddr),     64'd0);
    chk("rst_pwdata",    64'(bus.pwdata),    64'd0);
    chk("rst_pstrb",     64'(bus.pstrb),     64'd0);
    chk("rst_pprot",     64'(bus.pprot),     64'd0);
    chk("rst3_req_ready", 64'(bus3.req_ready), 64'd1);
    chk("rst3_pselx",     64'(bus3.pselx),     64'd0);
    prst = 1'b0;
    tick;

    // Table-driven transfers, issued back to back on the main bridge.
    for (int k = 0; k < 6; k++) runTxn(vecs[k], $sformatf("vec%0d", k));

    // Decode error on a 3-slave bridge: slave index 3 does not exist.
    bus3.req_valid = 1'b1; bus3.req_write = 1'b0; bus3.req_addr = 32'h0000_3000;
    tick;
    bus3.req_valid = 1'b0;
    chk("dec_pselx",     64'(bus3.pselx),     64'd0);
    chk("dec_penable",   64'(bus3.penable),   64'd0);
    chk("dec_rsp_valid", 64'(bus3.rsp_valid), 64'd1);
    chk("dec_rsp_err",   64'(bus3.rsp_err),   64'd1);
    chk("dec_rsp_rdata", 64'(bus3.rsp_rdata), 64'd0);
    chk("dec_req_ready", 64'(bus3.req_ready), 64'd0);
    tick;
    chk("dec_hold_pselx", 64'(bus3.pselx),     64'd0);
    chk("dec_hold_valid", 64'(bus3.rsp_valid), 64'd1);
    bus3.rsp_ready = 1'b1;
    tick;
    bus3.rsp_ready = 1'b0;
    chk("dec_done_valid", 64'(bus3.rsp_valid), 64'd0);
    chk("dec_done_ready", 64'(bus3.req_ready), 64'd1);

    // Highest legal slave on the 3-slave bridge still decodes.
    bus3.prdata[2*DW +: DW] = 32'h2222_3333;
    bus3.req_valid = 1'b1; bus3.req_addr = 32'h0000_2000;
    tick;
    bus3.req_valid = 1'b0;
    chk("s3_setup_pselx", 64'(bus3.pselx), 64'h4);
    tick;
    chk("s3_acc_penable", 64'(bus3.penable), 64'd1);
    tick;
    chk("s3_rsp_valid", 64'(bus3.rsp_valid), 64'd1);
    chk("s3_rsp_rdata", 64'(bus3.rsp_rdata), 64'h2222_3333);
    chk("s3_rsp_err",   64'(bus3.rsp_err),   64'd0);
    bus3.rsp_ready = 1'b1;
    tick;
    bus3.rsp_ready = 1'b0;

    // Reset while in ACCESS aborts without a response.
    bus.pready = '0; bus.pslverr = '0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_1000;
    tick;
    bus.req_valid = 1'b0;
    tick;
    tick;
    chk("rsta_in_access", 64'(bus.penable), 64'd1);
    prst = 1'b1;
    tick;
    prst = 1'b0;
    chk("rsta_pselx",     64'(bus.pselx),     64'd0);
    chk("rsta_penable",   64'(bus.penable),   64'd0);
    chk("rsta_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rsta_req_ready", 64'(bus.req_ready), 64'd1);
    tick;
    chk("rsta_no_rsp", 64'(bus.rsp_valid), 64'd0);
    runTxn(vecs[3], "after_rst");

    // Slave 1 never raises pready.
    bus.pready = '0; bus.pslverr = '0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_1000;
    tick;
    bus.req_valid = 1'b0;
    tick;
    accCycles = 1;
    got = 1'b0;
    seen = 0;
`ifdef APB_TIMEOUT_EN
    for (int k = 0; k < 40; k++) begin
      tick;
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
      accCycles++;
    end
    chk("to_seen",     64'(got),           64'd1);
    chk("to_cycles",   64'(accCycles),     64'd8);
    chk("to_err",      64'(bus.rsp_err),   64'd1);
    chk("to_rdata",    64'(bus.rsp_rdata), 64'd0);
    chk("to_pselx",    64'(bus.pselx),     64'd0);
    chk("to_penable",  64'(bus.penable),   64'd0);
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    chk("to_done_ready", 64'(bus.req_ready), 64'd1);
`else
    for (int k = 0; k < 1000; k++) begin
      tick;
      if (bus.rsp_valid) seen++;
    end
    chk("nto_no_rsp",  64'(seen),        64'd0);
    chk("nto_penable", 64'(bus.penable), 64'd1);
    chk("nto_pselx",   64'(bus.pselx),   64'h2);
    prst = 1'b1;
    tick;
    prst = 1'b0;
    chk("nto_rst_ready", 64'(bus.req_ready), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Registered APB master that converts a valid/ready command stream into full APB SETUP/ACCESS transfers.
- Routes each transfer to one of NUM_SLAVES slaves by address decode.
- Returns read data and error status on a valid/ready response stream.
- Parametrised successor of the team's combinational APB master pass-through; sits between the AXI4-Lite front end and the APB slave fabric.

Parameters:
- dataWidth, 32, APB/command data width; must be a multiple of 8.
- addrWidth, 32, APB/command address width.
- NUM_SLAVES, 4, number of APB slaves (pselx/pready/pslverr/prdata lanes); 1..16.
- SEL_LSB, 12, LSB of the slave-index field in req_addr; field width SELW = max(1, $clog2(NUM_SLAVES)).
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit (used only with APB_TIMEOUT_EN); >= 2.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- prst  in  1  synchronous, active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  addrWidth  byte address.
- req_wdata  in  dataWidth  write data.
- req_strb  in  dataWidth/8  write strobes; forced to 0 on reads.
- req_prot  in  3  protection attributes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  dataWidth  read data; 0 for writes.
- rsp_err  out  1  pslverr, decode error or timeout.
- pselx  out  NUM_SLAVES  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  addrWidth  APB address.
- pwdata  out  dataWidth  APB write data.
- pstrb  out  dataWidth/8  APB strobes.
- pprot  out  3  APB protection.
- pready  in  NUM_SLAVES  per-slave ready.
- pslverr  in  NUM_SLAVES  per-slave error.
- prdata  in  NUM_SLAVES*dataWidth  per-slave read data; slave i occupies bits [i*dataWidth +: dataWidth].

Behaviour:
- Reset (prst=1 at a pclk edge): state IDLE.
  - All outputs 0 except req_ready, which is 1.
  - Reset mid-transfer aborts immediately: pselx/penable drop on the next edge and no response is produced.
- All APB and response outputs are registered; no combinational path from pready/prdata to any output.
- FSM:
  - IDLE: req_ready=1.
    - On handshake, capture cmd; idx = req_addr[SEL_LSB +: SELW].
    - If idx < NUM_SLAVES: go to SETUP and drive pselx[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb/pprot from the captured cmd.
    - Else (decode error): go to RESP with rsp_err=1, rsp_rdata=0, no APB activity.
  - SETUP: one cycle; penable goes to 1 on the next edge -> ACCESS.
  - ACCESS: wait for pready[idx]=1.
    - On that edge, latch rsp_rdata = prdata lane idx for reads (0 for writes) and rsp_err = pslverr[idx].
    - Deassert pselx and penable; go to RESP.
    - pready of unselected slaves is ignored.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready.
    - On handshake, go to IDLE with req_ready=1 the same edge.
- req_ready=0 in SETUP, ACCESS and RESP; one outstanding transfer max.
- APB address/control/data outputs are stable from SETUP through ACCESS completion. After completion they hold their last values; only pselx and penable return to 0.
- Latency, zero-wait slave with rsp_ready tied high:
  - handshake at edge 0;
  - SETUP visible after edge 0;
  - ACCESS after edge 1;
  - pready sampled at edge 2;
  - rsp_valid after edge 2.
  - Throughput is one transfer per 4 cycles.
- Back-to-back commands: the next req is accepted only in IDLE. No SETUP is skipped: penable is never 1 on the first selected cycle.
- NUM_SLAVES=1: SELW=1; any address with the select bit at 1 is a decode error.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to ACCESS and increments each ACCESS cycle without pready[idx].
  - When it reaches TIMEOUT_CYCLES: abort, deassert pselx/penable, go to RESP with rsp_err=1, rsp_rdata=0.
- Undefined: no counter logic; ACCESS waits indefinitely.

Test Plan:
- Zero-wait write: req addr=0x0000_1004, wdata=0xDEADBEEF, strb=0xF -> pselx=4'b0010 for 2 cycles; penable only in cycle 2; pwdata=0xDEADBEEF; rsp_valid 3 cycles after accept; rsp_err=0; rsp_rdata=0.
- Read with 3 wait states from slave 3 (addr=0x0000_3000, prdata lane3=0x12345678) -> ACCESS lasts 4 cycles with signals stable; rsp_rdata=0x12345678; read pstrb=0.
- pslverr: slave 2 asserts pready and pslverr together -> rsp_err=1; with rsp_ready held low for 5 cycles, rsp_valid and data stay stable and req_ready=0 throughout.
- Decode error with NUM_SLAVES=3, addr=0x0000_3000 -> pselx stays 0; rsp_valid 1 cycle after accept; rsp_err=1.
- prst asserted during ACCESS -> next edge: pselx=0, penable=0, rsp_valid=0, req_ready=1; a new read completes normally.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and pready never asserted -> rsp_err=1 after 8 ACCESS cycles; without the macro the bench sees no response after 1000 cycles.
